bm_buf_mw: RTL and testbench



---
 rtl/bm_buf_mw_pkg.sv | 26 ++
 rtl/bm_buf_mw_ser.sv | 77 +++++++
 rtl/bm_buf_mw.sv | 114 +++++++++++
 tb/tb_bm_buf_mw.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bm_buf_mw_pkg.sv
// Shared types and helpers for the multi-lane replay buffer (bm_buf_mw) and its serialiser.
package bm_buf_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SER  = 1'b1
    } ser_state_t;

    function automatic int calc_lanes(input int data_w, input int out_w);
        return data_w / out_w;
    endfunction

    // Needs at least two lanes so the lane counter and word index split are non-empty.
    function automatic int calc_lw(input int lanes);
        return $clog2(lanes);
    endfunction

    // Pointer distance a - b, modulo 2**pw.
    function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b,
                                             input int pw);
        logic [31:0] mask;
        mask = (pw >= 32) ? '1 : ((32'd1 << pw) - 32'd1);
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/bm_buf_mw_ser.sv
// Word register and lane serialiser: latches an accepted word and emits one
// OUT_W symbol per cycle, MSB lane first, with no gap between back-to-back words.
module bm_ser
    import bm_buf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OUT_W  = 8
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_vld,
    output logic              in_rdy,
    output logic              wr_en,
    output logic [OUT_W-1:0]  wr_sym
);

    localparam int LANES = calc_lanes(DATA_W, OUT_W);
    localparam int LW    = calc_lw(LANES);
    localparam logic [LW-1:0] LAST = LW'(LANES - 1);

    ser_state_t        state;
    logic [LW-1:0]     lane;
    logic [DATA_W-1:0] word_reg;

    // in_rdy is registered: it anticipates IDLE or the last lane of the next cycle.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state  <= IDLE;
            lane   <= '0;
            in_rdy <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_vld) begin
                        state  <= SER;
                        lane   <= '0;
                        in_rdy <= 1'b0;
                    end
                end
                SER: begin
                    if (lane == LAST) begin
                        lane <= '0;
                        if (in_vld) begin
                            in_rdy <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            in_rdy <= 1'b1;
                        end
                    end else begin
                        lane   <= lane + 1'b1;
                        in_rdy <= ((lane + 1'b1) == LAST);
                    end
                end
                default: begin
                    state  <= IDLE;
                    lane   <= '0;
                    in_rdy <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (in_vld && in_rdy) word_reg <= in_data;
    end

    assign wr_en = (state == SER);

    always_comb begin
        wr_sym = word_reg[DATA_W-1 -: OUT_W];
        for (int i = 0; i < LANES; i++) begin
            if (lane == LW'(i)) wr_sym = word_reg[DATA_W-1-i*OUT_W -: OUT_W];
        end
    end

endmodule

// File: rtl/bm_buf_mw.sv
// Multi-lane circular replay buffer: serialises words into a dual-port RAM and replays
// from LOOKBACK words behind the write point. Define BM_BUF_MW_OVF_CNT_EN for the ovf_cnt port.
module bm_buf_mw
    import bm_buf_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int OUT_W    = 8,
    parameter int ADDR_W   = 15,
    parameter int LOOKBACK = 4
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic              rd_req,
    output logic [OUT_W-1:0]  out_q,
    output logic              out_vld,
    output logic [ADDR_W:0]   fill,
    output logic              ovf
`ifdef BM_BUF_MW_OVF_CNT_EN
    ,
    output logic [15:0]       ovf_cnt
`endif
);

    localparam int LANES = calc_lanes(DATA_W, OUT_W);
    localparam int LW    = calc_lw(LANES);
    localparam int PW    = ADDR_W + 1;
    localparam int WW    = PW - LW;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CW    = $clog2(LOOKBACK + 1);

    logic              wr_en;
    logic [OUT_W-1:0]  wr_sym;
    logic              accept;
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [PW-1:0]     rptr_lb;
    logic [WW-1:0]     widx_lb;
    logic [CW-1:0]     wcnt;
    logic              rd_issue;
    logic              ovf_set;
    logic              vld_p0;
    logic [OUT_W-1:0]  ram_q_p0;
    logic [OUT_W-1:0]  mem [DEPTH];

    bm_ser #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) u_ser (
        .clk_sys (clk_sys),
        .rst     (rst),
        .in_data (in_data),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .wr_en   (wr_en),
        .wr_sym  (wr_sym)
    );

    assign accept   = in_vld && in_rdy;
    assign rd_issue = rd_req && (rptr != wptr);
    assign widx_lb  = wptr[ADDR_W:LW] - WW'(LOOKBACK);
    assign rptr_lb  = {widx_lb, {LW{1'b0}}};
    // A write that would land exactly DEPTH ahead of the reader counts as an overrun.
    assign ovf_set  = rd_req && wr_en &&
                      (PW'(ptr_diff(32'(wptr + 1'b1), 32'(rptr), PW)) == PW'(DEPTH));

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            wcnt <= '0;
            fill <= '0;
            ovf  <= 1'b0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (accept && (wcnt < CW'(LOOKBACK))) wcnt <= wcnt + 1'b1;
            // While idle the read pointer tracks the word-aligned lookback point.
            if (!rd_req) rptr <= (wcnt < CW'(LOOKBACK)) ? '0 : rptr_lb;
            else if (rd_issue) rptr <= rptr + 1'b1;
            fill <= PW'(ptr_diff(32'(wptr), 32'(rptr), PW));
            if (!rd_req) ovf <= 1'b0;
            else if (ovf_set) ovf <= 1'b1;
        end
    end

    // Simple dual-port RAM stage, read-first, one-cycle read.
    always_ff @(posedge clk_sys) begin
        if (wr_en) mem[wptr[ADDR_W-1:0]] <= wr_sym;
        if (rd_issue) ram_q_p0 <= mem[rptr[ADDR_W-1:0]];
    end

    // Output register stage.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            out_vld <= 1'b0;
            out_q   <= '0;
        end else begin
            vld_p0  <= rd_issue;
            out_vld <= vld_p0;
            if (vld_p0) out_q <= ram_q_p0;
        end
    end

`ifdef BM_BUF_MW_OVF_CNT_EN
    always_ff @(posedge clk_sys) begin
        if (rst || !rd_req) ovf_cnt <= '0;
        else if (ovf_set && (ovf_cnt != 16'hFFFF)) ovf_cnt <= ovf_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_bm_buf_mw.sv
// Scoreboard bench for bm_buf_mw: a default-size instance and a 16-symbol instance
// share one stimulus stream; monitors pop expected symbols on every out_vld.
module tb_bm_buf_mw;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_vld;
    logic        rd_req;

    logic        in_rdy_a, out_vld_a, ovf_a;
    logic [7:0]  out_q_a;
    logic [15:0] fill_a;
    logic        in_rdy_b, out_vld_b, ovf_b;
    logic [7:0]  out_q_b;
    logic [4:0]  fill_b;
`ifdef BM_BUF_MW_OVF_CNT_EN
    logic [15:0] ovf_cnt_a, ovf_cnt_b;
`endif

    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_out_a = 0;
    int          n_out_b = 0;
    logic        fill_watch = 1'b0;
    logic [7:0]  exp_a[$];
    logic [7:0]  exp_b[$];
    logic [31:0] hist[$];
    int          stall;

    always #5 clk_sys = ~clk_sys;

    bm_buf_mw u_a (
        .clk_sys (clk_sys), .rst (rst),
        .in_data (in_data), .in_vld (in_vld), .in_rdy (in_rdy_a),
        .rd_req  (rd_req),  .out_q (out_q_a), .out_vld (out_vld_a),
        .fill    (fill_a),  .ovf (ovf_a)
`ifdef BM_BUF_MW_OVF_CNT_EN
        , .ovf_cnt (ovf_cnt_a)
`endif
    );

    bm_buf_mw #(.ADDR_W(4)) u_b (
        .clk_sys (clk_sys), .rst (rst),
        .in_data (in_data), .in_vld (in_vld), .in_rdy (in_rdy_b),
        .rd_req  (rd_req),  .out_q (out_q_b), .out_vld (out_vld_b),
        .fill    (fill_b),  .ovf (ovf_b)
`ifdef BM_BUF_MW_OVF_CNT_EN
        , .ovf_cnt (ovf_cnt_b)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk_sys) begin
        if (out_vld_a) begin
            n_out_a++;
            if (exp_a.size() == 0) check("a_unexpected_vld", 32'd1, 32'd0);
            else check("a_sym", {24'd0, out_q_a}, {24'd0, exp_a.pop_front()});
        end
        if (out_vld_b) begin
            n_out_b++;
            if (exp_b.size() == 0) check("b_unexpected_vld", 32'd1, 32'd0);
            else check("b_sym", {24'd0, out_q_b}, {24'd0, exp_b.pop_front()});
        end
        if (fill_watch) check("b_fill_le4", {31'd0, (fill_b <= 5'd4)}, 32'd1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_vld = 1'b0; rd_req = 1'b0; in_data = '0;
        tick(2);
        rst = 1'b0;
        hist.delete();
        n_out_a = 0;
        n_out_b = 0;
    endtask

    // Presents one word and returns right after the edge that accepts it.
    task automatic push_word(input logic [31:0] w, output int stalls);
        hist.push_back(w);
        in_data = w;
        in_vld  = 1'b1;
        stalls  = 0;
        while (!in_rdy_a && stalls < 20) begin
            tick(1);
            stalls++;
        end
        if (stalls >= 20) check("push_timeout", 32'd0, 32'd1);
        tick(1);
        in_vld = 1'b0;
    endtask

    task automatic expect_words(input int first, input int last);
        logic [31:0] w;
        for (int i = first; i <= last; i++) begin
            w = hist[i];
            for (int l = 0; l < 4; l++) begin
                exp_a.push_back(w[31-8*l -: 8]);
                exp_b.push_back(w[31-8*l -: 8]);
            end
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (exp_a.size() == 0 && exp_b.size() == 0 && !out_vld_a && !out_vld_b) break;
        end
        check({name, "_a_left"}, exp_a.size(), 32'd0);
        check({name, "_b_left"}, exp_b.size(), 32'd0);
        exp_a.delete();
        exp_b.delete();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("rst_in_rdy",  {31'd0, in_rdy_a},  32'd1);
        check("rst_out_vld", {31'd0, out_vld_a}, 32'd0);
        check("rst_out_q",   {24'd0, out_q_a},   32'd0);
        check("rst_fill",    {16'd0, fill_a},    32'd0);
        check("rst_ovf",     {31'd0, ovf_a},     32'd0);

        // Three back-to-back words, then replay from address 0.
        push_word(32'h11223344, stall);
        push_word(32'h55667788, stall);
        check("t1_gap_w1", stall, 32'd3);
        push_word(32'h99AABBCC, stall);
        check("t1_gap_w2", stall, 32'd3);
        tick(4);
        check("t1_wptr", {16'd0, u_a.wptr}, 32'd12);
        check("t1_in_rdy_idle", {31'd0, in_rdy_a}, 32'd1);
        tick(2);
        rd_req = 1'b1;
        expect_words(0, 2);
        drain("t1");
        check("t1_fill", {16'd0, fill_a}, 32'd0);
        check("t1_nout", n_out_a, 32'd12);
        rd_req = 1'b0;

        // Ten words, replay starts at word 6 (address 24).
        do_reset();
        for (int i = 0; i < 10; i++) push_word(32'h00010203 + i * 32'h04040404, stall);
        tick(6);
        rd_req = 1'b1;
        expect_words(6, 9);
        tick(1);
        check("t2_vld_lat1", {31'd0, out_vld_a}, 32'd0);
        tick(1);
        check("t2_vld_lat2", {31'd0, out_vld_a}, 32'd1);
        check("t2_first_q", {24'd0, out_q_a}, 32'h18);
        drain("t2");
        check("t2_nout", n_out_a, 32'd16);
        check("t2_fill", {16'd0, fill_a}, 32'd0);
        check("t2_vld_end", {31'd0, out_vld_a}, 32'd0);
        check("t2_b_nout", n_out_b, 32'd16);
        rd_req = 1'b0;

        // Short history: replay from address 0.
        do_reset();
        push_word(32'hA1A2A3A4, stall);
        push_word(32'hB1B2B3B4, stall);
        tick(6);
        rd_req = 1'b1;
        expect_words(0, 1);
        drain("t3");
        check("t3_nout", n_out_a, 32'd8);
        check("t3_ovf", {31'd0, ovf_a}, 32'd0);
        rd_req = 1'b0;

        // Overrun on the 16-symbol instance: reader starts a full buffer behind.
        do_reset();
        for (int i = 0; i < 4; i++) push_word(32'h00010203 + i * 32'h04040404, stall);
        tick(6);
        check("t4_fill_full", {27'd0, fill_b}, 32'd16);
        check("t4_ovf_pre", {31'd0, ovf_b}, 32'd0);
        rd_req = 1'b1;
        push_word(32'h10111213, stall);
        expect_words(0, 4);
        drain("t4");
        check("t4_ovf_b", {31'd0, ovf_b}, 32'd1);
        check("t4_ovf_a", {31'd0, ovf_a}, 32'd0);
`ifdef BM_BUF_MW_OVF_CNT_EN
        check("t4_ovf_cnt_b", {16'd0, ovf_cnt_b}, 32'd4);
        check("t4_ovf_cnt_a", {16'd0, ovf_cnt_a}, 32'd0);
`endif
        rd_req = 1'b0;
        tick(1);
        check("t4_ovf_clear", {31'd0, ovf_b}, 32'd0);

        // Continuous write across the address wrap with live replay.
        do_reset();
        rd_req = 1'b1;
        fill_watch = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_word(32'h00010203 + i * 32'h04040404, stall);
            expect_words(i, i);
        end
        drain("t5");
        fill_watch = 1'b0;
        check("t5_b_nout", n_out_b, 32'd24);
        check("t5_ovf_b", {31'd0, ovf_b}, 32'd0);
        rd_req = 1'b0;

        // Reset during lane 2 abandons the word and clears the read pipeline.
        do_reset();
        rd_req = 1'b1;
        push_word(32'hDEADBEEF, stall);
        tick(2);
        rst = 1'b1;
        tick(1);
        check("t6_wptr",    {16'd0, u_a.wptr}, 32'd0);
        check("t6_in_rdy",  {31'd0, in_rdy_a}, 32'd1);
        check("t6_out_vld", {31'd0, out_vld_a}, 32'd0);
        check("t6_ovf",     {31'd0, ovf_a}, 32'd0);
        rst = 1'b0;
        rd_req = 1'b0;
        hist.delete();
        tick(1);
        check("t6_fill", {16'd0, fill_a}, 32'd0);
        push_word(32'h0F1E2D3C, stall);
        tick(6);
        rd_req = 1'b1;
        expect_words(0, 0);
        drain("t6");
        rd_req = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
